// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: request/response bundle between the MEM stage (master) and
// the data-memory controller (slave).
//
// Handshake: a request transfers on a rising clock edge where req_i and
// ready_o are both 1. The master holds req_i/we_i/size_i/addr_i/wdata_i
// stable while req_i is 1 and ready_o is 0; the slave latches them at the
// transfer edge, so they may change freely afterwards. Every accepted request
// produces exactly one done_o pulse; loads also pulse rvalid_o in that cycle,
// faulting requests pulse err_o in that cycle.
//
// Signals:
//   req_i   request valid              ready_o  slave can accept (IDLE only)
//   we_i    1 = store, 0 = load        done_o   completion pulse
//   size_i  1 = byte, 0 = word         rvalid_o load data valid pulse
//   addr_i  byte address (LE)          rdata_o  right-aligned load data
//   wdata_i store data                 count_o  size of returned load (1 = byte)
//                                      err_o    fault pulse (with done_o)
interface dmem_ctrl_if;
  logic        req_i;
  logic        we_i;
  logic        size_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic        done_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        count_o;
  logic        err_o;

  modport master (
    output req_i, we_i, size_i, addr_i, wdata_i,
    input  ready_o, done_o, rvalid_o, rdata_o, count_o, err_o
  );

  modport slave (
    input  req_i, we_i, size_i, addr_i, wdata_i,
    output ready_o, done_o, rvalid_o, rdata_o, count_o, err_o
  );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle data-memory controller. Owns a 2^ADDR_W x 32-bit
// synchronous RAM and serves word/byte loads and stores one at a time over a
// ready/valid handshake (see dmem_ctrl_if). Byte stores use read-modify-write.
// Loads return a right-aligned word plus a size flag (count_o) that the
// downstream sign-extension stage consumes directly.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous reset, active low (RAM contents are kept)
//   bus          dmem_ctrl_if.slave request/response bundle
//   dbg_state_o  current FSM state, for observation only
//
// Build option:
//   DMEM_ERR_EN  when defined, misaligned word accesses and addresses beyond
//                the RAM fault (ERR state, err_o pulse). When undefined, upper
//                address bits wrap and misaligned words use lane 0.
module dmem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_ctrl_if.slave  bus,
  output logic [2:0]  dbg_state_o
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RESP = 3'd2,
    S_RMW  = 3'd3,
    S_WR   = 3'd4
`ifdef DMEM_ERR_EN
    , S_ERR = 3'd5
`endif
  } state_t;

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                count_q, count_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [1:0]          lane_q, lane_d;
  logic                size_q, size_d;
  logic [7:0]          byte_q, byte_d;
  logic [31:0]         wr_word_q, wr_word_d;

  logic [31:0]         mem [DEPTH];
  logic [31:0]         ram_q;
  logic [ADDR_W-1:0]   rd_idx;
  logic [31:0]         lane_shift;
  logic [31:0]         merged;
  logic                fault;

`ifdef DMEM_ERR_EN
  assign fault = (!bus.size_i && (bus.addr_i[1:0] != 2'b00)) ||
                 (bus.addr_i[31:ADDR_W+2] != '0);
`else
  // Upper address bits are deliberately ignored: accesses wrap the RAM.
  logic unused_upper_addr;
  assign unused_upper_addr = ^bus.addr_i[31:ADDR_W+2];
  assign fault = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ready_d   = 1'b0;
    done_d    = 1'b0;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    count_d   = count_q;
    idx_d     = idx_q;
    lane_d    = lane_q;
    size_d    = size_q;
    byte_d    = byte_q;
    wr_word_d = wr_word_q;
    rd_idx    = idx_q;

    lane_shift = ram_q >> {lane_q, 3'b000};
    merged     = ram_q;
    merged[{lane_q, 3'b000} +: 8] = byte_q;

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        // The RAM read is launched at the acceptance edge, so the word is
        // already in ram_q during RD/RMW and the registered result lands
        // one cycle later.
        rd_idx  = bus.addr_i[ADDR_W+1:2];
        if (bus.req_i) begin
          ready_d = 1'b0;
          idx_d   = bus.addr_i[ADDR_W+1:2];
          // Word accesses always use lane 0, so a misaligned word address
          // (no fault checking) still returns/writes the whole word.
          lane_d  = bus.size_i ? bus.addr_i[1:0] : 2'b00;
          size_d  = bus.size_i;
          byte_d  = bus.wdata_i[7:0];
`ifdef DMEM_ERR_EN
          if (fault) begin
            state_d = S_ERR;
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else
`endif
          if (!bus.we_i) begin
            state_d = S_RD;
          end else if (bus.size_i) begin
            state_d = S_RMW;
          end else begin
            state_d   = S_WR;
            done_d    = 1'b1;
            wr_word_d = bus.wdata_i;
          end
        end
      end
      S_RD: begin
        state_d  = S_RESP;
        rvalid_d = 1'b1;
        done_d   = 1'b1;
        rdata_d  = size_q ? {24'b0, lane_shift[7:0]} : ram_q;
        count_d  = size_q;
      end
      S_RMW: begin
        state_d   = S_WR;
        done_d    = 1'b1;
        wr_word_d = merged;
      end
`ifdef DMEM_ERR_EN
      S_ERR: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
`endif
      default: begin
        // RESP and WR both complete in one cycle and return to IDLE.
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // Outputs are registered alongside the state: their _d values describe
  // the state being entered, so they are valid for the whole of that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      count_q   <= 1'b0;
      idx_q     <= '0;
      lane_q    <= 2'b00;
      size_q    <= 1'b0;
      byte_q    <= '0;
      wr_word_q <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      lane_q    <= lane_d;
      size_q    <= size_d;
      byte_q    <= byte_d;
      wr_word_q <= wr_word_d;
    end
  end

  // RAM: no reset. The write only happens in WR, so a reset that lands in
  // RMW abandons the byte store before anything reaches the array.
  always_ff @(posedge clk) begin
    if (state_q == S_WR) begin
      mem[idx_q] <= wr_word_q;
    end
    ram_q <= mem[rd_idx];
  end

  assign bus.ready_o  = ready_q;
  assign bus.done_o   = done_q;
  assign bus.rvalid_o = rvalid_q;
  assign bus.err_o    = err_q;
  assign bus.rdata_o  = rdata_q;
  assign bus.count_o  = count_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed + randomized bench for dmem_ctrl (ADDR_W = 8).
// The reference model is a plain word array indexed by (addr / 4) % 256,
// with byte lanes handled arithmetically; expected load data goes through
// exp_q in request order.
module tb_dmem_ctrl;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  dmem_ctrl_if bus ();

  dmem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_mem [DEPTH];
  logic [31:0] hold_rdata = '0;
  logic        hold_count = 1'b0;
  logic [31:0] last_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic bit model_fault(input logic sz, input logic [31:0] a);
`ifdef DMEM_ERR_EN
    return (!sz && (a % 4) != 0) || (a >= 4 * DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic sz, input logic [31:0] a);
    logic [31:0] w;
    int lane;
    w    = model_mem[widx(a)];
    lane = int'(a % 4);
    if (sz) return (w >> (8 * lane)) & 32'h0000_00FF;
    return w;
  endfunction

  task automatic model_store(input logic sz, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] w;
    int lane;
    w    = model_mem[widx(a)];
    lane = int'(a % 4);
    if (sz) model_mem[widx(a)] = (w & ~(32'h0000_00FF << (8 * lane))) |
                                 ((wd & 32'h0000_00FF) << (8 * lane));
    else    model_mem[widx(a)] = wd;
  endtask

  // ---------------- drivers ----------------
  // Present a request at a negedge once ready_o is seen, hold it over the
  // accepting posedge, then drop req_i and scramble the fields.
  task automatic start_req(input logic we, input logic sz, input logic [31:0] a,
                           input logic [31:0] wd);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.ready_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", bus.ready_o, 1'b1);
    bus.req_i   = 1'b1;
    bus.we_i    = we;
    bus.size_i  = sz;
    bus.addr_i  = a;
    bus.wdata_i = wd;
    @(posedge clk);
    #1;
    bus.req_i   = 1'b0;
    bus.we_i    = 1'($urandom);
    bus.size_i  = 1'($urandom);
    bus.addr_i  = $urandom;
    bus.wdata_i = $urandom;
  endtask

  // Full transaction: latency, response flags, data and hold behaviour.
  task automatic issue(input logic we, input logic sz, input logic [31:0] a,
                       input logic [31:0] wd);
    bit          e;
    bit          is_load;
    int          exp_lat;
    int          lat;
    logic [31:0] exp_data;
    e       = model_fault(sz, a);
    is_load = !we && !e;
    exp_lat = e ? 1 : (!we ? 2 : (sz ? 2 : 1));
    if (is_load) exp_q.push_back(model_load(sz, a));
    start_req(we, sz, a, wd);
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) begin
        lat = c;
        break;
      end
    end
    chk("latency", lat, exp_lat);
    chk("err", bus.err_o, e);
    chk("rvalid", bus.rvalid_o, is_load);
    if (is_load) begin
      exp_data = exp_q.pop_front();
      chk("rdata", bus.rdata_o, exp_data);
      chk("count", bus.count_o, sz);
      hold_rdata = exp_data;
      hold_count = sz;
    end else if (e) begin
      chk("err_rdata_zero", bus.rdata_o, 32'h0);
      hold_rdata = '0;
    end else begin
      chk("rdata_hold", bus.rdata_o, hold_rdata);
      chk("count_hold", bus.count_o, hold_count);
    end
    last_rdata = bus.rdata_o;
    if (we && !e) model_store(sz, a, wd);
    @(negedge clk);
    chk("done_pulse", bus.done_o, 1'b0);
    chk("ready_back", bus.ready_o, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  logic        b_we [3];
  logic        b_sz [3];
  logic [31:0] b_a  [3];
  logic [31:0] b_wd [3];

  initial begin
    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.size_i  = 1'b0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;

    // Reset state
    #12;
    chk("rst_ready", bus.ready_o, 1'b1);
    chk("rst_done", bus.done_o, 1'b0);
    chk("rst_rvalid", bus.rvalid_o, 1'b0);
    chk("rst_err", bus.err_o, 1'b0);
    chk("rst_rdata", bus.rdata_o, 32'h0);
    chk("rst_count", bus.count_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill words 0..15 so every later read has a known value
    for (int w = 0; w < 16; w++) issue(1'b1, 1'b0, 32'(w * 4), $urandom);

    // Word store then word load
    issue(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
    issue(1'b0, 1'b0, 32'h10, 32'h0);
    chk("plan_word_load", last_rdata, 32'hDEAD_BEEF);

    // Byte store into lane 2 then word load
    issue(1'b1, 1'b1, 32'h12, 32'hFFFF_FF5A);
    issue(1'b0, 1'b0, 32'h10, 32'h0);
    chk("plan_rmw_word", last_rdata, 32'hDE5A_BEEF);

    // Byte load from lane 3
    issue(1'b0, 1'b1, 32'h13, 32'h0);
    chk("plan_byte_load", last_rdata, 32'h0000_00DE);

    // Reset in the middle of a byte store (RMW cycle)
    start_req(1'b1, 1'b1, 32'h25, 32'h0000_00A5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", bus.ready_o, 1'b1);
    chk("midrst_done", bus.done_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    hold_rdata = '0;
    hold_count = 1'b0;
    issue(1'b0, 1'b0, 32'h24, 32'h0);
    chk("midrst_word_kept", last_rdata, model_mem[9]);

    // Back-to-back with req_i held high: store, load, byte load
    b_we[0] = 1'b1; b_sz[0] = 1'b0; b_a[0] = 32'h20; b_wd[0] = $urandom;
    b_we[1] = 1'b0; b_sz[1] = 1'b0; b_a[1] = 32'h20; b_wd[1] = '0;
    b_we[2] = 1'b0; b_sz[2] = 1'b1; b_a[2] = 32'h21; b_wd[2] = '0;
    begin
      int k;
      int dones;
      int last_done_c;
      k = 0;
      dones = 0;
      last_done_c = -1;
      @(negedge clk);
      for (int c = 0; c < 20; c++) begin
        if (c > 0) @(negedge clk);
        if (bus.done_o === 1'b1) begin
          dones++;
          last_done_c = c;
        end
        if (bus.rvalid_o === 1'b1) begin
          if (exp_q.size() > 0) chk("b2b_rdata", bus.rdata_o, exp_q.pop_front());
          else chk("b2b_extra_rvalid", bus.rvalid_o, 1'b0);
        end
        if (bus.ready_o === 1'b1) begin
          if (k < 3) begin
            bus.req_i   = 1'b1;
            bus.we_i    = b_we[k];
            bus.size_i  = b_sz[k];
            bus.addr_i  = b_a[k];
            bus.wdata_i = b_wd[k];
            if (b_we[k]) model_store(b_sz[k], b_a[k], b_wd[k]);
            else exp_q.push_back(model_load(b_sz[k], b_a[k]));
            k++;
          end else begin
            bus.req_i = 1'b0;
          end
        end
      end
      bus.req_i = 1'b0;
      chk("b2b_dispatched", k, 3);
      chk("b2b_dones", dones, 3);
      chk("b2b_last_done_cycle", last_done_c, 7);
      chk("b2b_exp_q_empty", exp_q.size(), 0);
      exp_q.delete();
      hold_rdata = model_load(1'b1, 32'h21);
      hold_count = 1'b1;
    end

`ifdef DMEM_ERR_EN
    // Faulting requests: misaligned word load, out-of-range load, bad store
    issue(1'b0, 1'b0, 32'h11, 32'h0);
    issue(1'b0, 1'b0, 32'h400, 32'h0);
    issue(1'b1, 1'b0, 32'h13, 32'h1234_5678);
    issue(1'b0, 1'b0, 32'h10, 32'h0);
    chk("err_ram_unchanged", last_rdata, 32'hDE5A_BEEF);
`else
    // Upper bits wrap: 0x400 aliases word 0
    issue(1'b0, 1'b0, 32'h400, 32'h0);
    chk("wrap_0x400", last_rdata, model_mem[0]);
`endif

    // Randomized traffic over words 0..15
    for (int t = 0; t < 40; t++) begin
      logic        we;
      logic        sz;
      logic [31:0] a;
      int          w;
      int          lane;
      we   = 1'($urandom);
      sz   = 1'($urandom);
      w    = $urandom_range(0, 15);
      lane = $urandom_range(0, 3);
`ifdef DMEM_ERR_EN
      if (!sz) lane = 0;
      a = 32'(w * 4 + lane);
`else
      a = 32'(w * 4 + lane) + 32'($urandom_range(0, 7) * 4 * DEPTH);
`endif
      issue(we, sz, a, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
